// File: rtl/addsub_word_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract built from one 4-bit slice, LSB nibble first, one nibble per clock.
// Latency: start sampled in cycle 0 -> done pulse in cycle NSLICE+1; one operation per NSLICE+2 cycles.
// Backpressure: busy high in RUN/DONE; start is ignored while busy. Optional signed-overflow output under ADDSUB_OVF_EN.
module addsub_word_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout
`ifdef ADDSUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NSLICE = WIDTH / 4;
   localparam int IDXW   = $clog2(NSLICE);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic              mode_q;
   logic              carry_q;
   logic [IDXW-1:0]   idx;
   logic [3:0]        a_nib;
   logic [3:0]        b_nib;
   logic [4:0]        slice_sum;
   logic              last_slice;

   // State register; reset forces IDLE and discards any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (last_slice) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // The shared 4-bit slice: subtraction is a + ~b + 1, the +1 coming from carry_q seeded with mode.
   always_comb begin
      a_nib      = a_q[{idx, 2'b00} +: 4];
      b_nib      = b_q[{idx, 2'b00} +: 4] ^ {4{mode_q}};
      slice_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
      last_slice = (idx == IDX_LAST);
   end

   // Operand latch, nibble-by-nibble result build and final carry/overflow capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= 1'b0;
         carry_q <= 1'b0;
         idx     <= '0;
         result  <= '0;
         cout    <= 1'b0;
`ifdef ADDSUB_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  mode_q  <= mode;
                  carry_q <= mode;
                  idx     <= '0;
               end
            end
            S_RUN: begin
               result[{idx, 2'b00} +: 4] <= slice_sum[3:0];
               carry_q                   <= slice_sum[4];
               idx                       <= idx + 1'b1;
               if (last_slice) begin
                  cout <= slice_sum[4];
`ifdef ADDSUB_OVF_EN
                  // Signed overflow: operands agree in sign but the result sign differs.
                  ovf  <= (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ mode_q)) &&
                          (slice_sum[3] != a_q[WIDTH-1]);
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_word_sequencer.sv
// Testbench for addsub_word_sequencer (WIDTH=16).
// Directed spec vectors, handshake/reset scenarios and randomized operations against an arithmetic model.
// Build with ADDSUB_OVF_EN defined to also check the signed-overflow output.
module tb_addsub_word_sequencer;

   localparam int W      = 16;
   localparam int NSLICE = W / 4;
   localparam int LAT    = NSLICE + 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         mode;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
`ifdef ADDSUB_OVF_EN
   logic         ovf;
`endif

   int total = 0;
   int bad   = 0;

   addsub_word_sequencer #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .mode   (mode),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout)
`ifdef ADDSUB_OVF_EN
      ,
      .ovf    (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the whole words.
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                                 output logic [W-1:0] r, output logic c, output logic v);
      int unsigned ux;
      int unsigned uy;
      int          sx;
      int          sy;
      int          ss;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (!m) begin
         r = W'(ux + uy);
         c = (ux + uy) >= (1 << W);
         ss = sx + sy;
      end else begin
         r = W'(ux - uy);
         c = (ux >= uy);
         ss = sx - sy;
      end
      v = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
   endfunction

   // Issue one operation; optionally disturb inputs and pulse start while it runs.
   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                        input bit garble, input string tag);
      logic [W-1:0] er;
      logic         ec;
      logic         ev;
      int           lat;
      bit           got;
      model(x, y, m, er, ec, ev);
      @(negedge clk);
      start = 1'b1;
      a     = x;
      b     = y;
      mode  = m;
      lat   = 0;
      got   = 1'b0;
      while (lat < 20 && !got) begin
         @(negedge clk);
         lat++;
         if (done) begin
            got = 1'b1;
         end else begin
            if (lat == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
            if (garble) begin
               start = 1'($urandom_range(0, 1));
               a     = (lat == 1) ? 16'h1111 : W'($urandom);
               b     = W'($urandom);
               mode  = 1'($urandom_range(0, 1));
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      check({tag, "_done_seen"}, 32'(got), 32'd1);
      check({tag, "_latency"}, 32'(lat), 32'(LAT));
      check({tag, "_result"}, 32'(result), 32'(er));
      check({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef ADDSUB_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(ev));
`endif
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_hold"}, 32'(result), 32'(er));
   endtask

   initial begin
      int             ndone;
      int             dq[$];
      logic [W-1:0]   er;
      logic           ec;
      logic           ev;

      rst   = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
`ifdef ADDSUB_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst = 1'b0;

      // Directed vectors.
      do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, "add");
      check("add_literal", 32'(result), 32'h2201);
      do_op(16'h1234, 16'h0235, 1'b1, 1'b0, "sub_noborrow");
      check("sub_literal", 32'(result), 32'h0FFF);
      do_op(16'h0005, 16'h0007, 1'b1, 1'b0, "sub_borrow");
      check("sub_borrow_literal", 32'(result), 32'hFFFE);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_wrap");
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_sovf");
      do_op(16'h8000, 16'h0001, 1'b1, 1'b0, "sub_sovf");
      do_op(16'h0000, 16'h0000, 1'b1, 1'b0, "sub_zero");
      do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "add_max");

      // Start pulse and operand changes during RUN must be ignored.
      do_op(16'h1234, 16'h0FCD, 1'b0, 1'b1, "ignore_start");

      // start held high: one completion every NSLICE+2 cycles.
      model(16'h1234, 16'h0FCD, 1'b0, er, ec, ev);
      @(negedge clk);
      start = 1'b1;
      a     = 16'h1234;
      b     = 16'h0FCD;
      mode  = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         if (done) begin
            dq.push_back(k);
            check("held_result", 32'(result), 32'(er));
         end
         if (k == 17) start = 1'b0;
      end
      check("held_count", 32'(dq.size()), 32'd3);
      if (dq.size() == 3) begin
         check("held_first", 32'(dq[0]), 32'(LAT));
         check("held_period1", 32'(dq[1] - dq[0]), 32'(NSLICE + 2));
         check("held_period2", 32'(dq[2] - dq[1]), 32'(NSLICE + 2));
      end
      @(negedge clk);

      // Reset in cycle 2 of an operation: discarded, outputs cleared, no done.
      @(negedge clk);
      start = 1'b1;
      a     = 16'h1234;
      b     = 16'h0FCD;
      mode  = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_result", 32'(result), 32'd0);
      check("midrst_cout", 32'(cout), 32'd0);
      ndone = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("midrst_no_done", 32'(ndone), 32'd0);
      do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, "after_rst");

      // rst and start together: rst wins.
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      check("rst_start_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("rst_start_idle", 32'(busy), 32'd0);

      // Randomized operations with disturbed inputs during RUN.
      for (int n = 0; n < 30; n++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
